// File: rtl/conv_out_if.sv
// Word-stream handshake between the pixel packer and the DMA/CSR consumer.
interface conv_out_if #(
   parameter int WORD_W = 32
);
   logic              m_valid;
   logic              m_ready;
   logic              m_last;
   logic [WORD_W-1:0] m_data;

   modport master (output m_valid, m_data, m_last, input m_ready);
   modport slave  (input m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/conv_out_packer.sv
// Packs the conv core's pixel stream into bus words and buffers them in a FWFT FIFO.
// Optional macro CONV_OUT_FLUSH_EN: push a zero-padded partial word at frame end.
module conv_out_packer #(
   parameter int PIX_W      = 8,
   parameter int WORD_W     = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int FRAME_PIX  = 15876
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   input  logic                        valid_in,
   input  logic [PIX_W-1:0]            px_in,
   conv_out_if.master                  m,
   output logic                        frame_done,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] level
);
   localparam int P  = WORD_W / PIX_W;
   localparam int LW = (P > 1) ? $clog2(P) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
   localparam logic [LW-1:0] LANE_MAX = LW'(P - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(FRAME_PIX - 1);
   localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

   logic [LW-1:0]     lane;
   logic [CW-1:0]     pix_cnt;
   logic [WORD_W-1:0] acc;
   logic [WORD_W-1:0] word_cur;
   logic              last_pend;
   logic              last_cur;
   logic              accept;
   logic              is_last;
   logic              complete;
   logic              full;
   logic              pop;
   logic              push;
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic [WORD_W:0]   mem [FIFO_DEPTH];
   logic [WORD_W:0]   head;

   // A pixel arriving together with rst/clear is discarded.
   always_comb begin
      accept   = valid_in && !rst && !clear;
      word_cur = acc;
      word_cur[int'(lane) * PIX_W +: PIX_W] = px_in;
      is_last  = (pix_cnt == CNT_MAX);
      last_cur = last_pend || is_last;
`ifdef CONV_OUT_FLUSH_EN
      complete = accept && ((lane == LANE_MAX) || is_last);
`else
      complete = accept && (lane == LANE_MAX);
`endif
      full     = (level == DEPTH);
      head     = mem[rptr];
      pop      = m.m_valid && m.m_ready;
      push     = complete && (!full || pop);
   end

   assign m.m_valid = (level != '0);
   assign m.m_data  = m.m_valid ? head[WORD_W-1:0] : '0;
   assign m.m_last  = m.m_valid ? head[WORD_W] : 1'b0;

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= {last_cur, word_cur};
   end

   // acc is cleared on completion so a flushed partial word carries zero upper lanes.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         lane       <= '0;
         pix_cnt    <= '0;
         acc        <= '0;
         last_pend  <= 1'b0;
         wptr       <= '0;
         rptr       <= '0;
         level      <= '0;
         overflow   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= pop && head[WORD_W];
         if (accept) begin
            pix_cnt <= is_last ? '0 : pix_cnt + 1'b1;
            if (complete) begin
               lane      <= '0;
               acc       <= '0;
               last_pend <= 1'b0;
            end else begin
               lane      <= lane + 1'b1;
               acc       <= word_cur;
               last_pend <= last_cur;
            end
         end
         if (complete && !push) overflow <= 1'b1;
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         if (push && !pop) level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
      end
   end
endmodule

// File: tb/tb_conv_out_packer.sv
// Self-checking bench for conv_out_packer with a small-frame, shallow-FIFO configuration.
module tb_conv_out_packer;
   localparam int PIX_W = 8;
   localparam int WORD_W = 32;
   localparam int DEPTH = 4;
   localparam int FRAME_PIX = 6;
   localparam int P = WORD_W / PIX_W;
`ifdef CONV_OUT_FLUSH_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clear = 1'b0;
   logic valid_in = 1'b0;
   logic [PIX_W-1:0] px_in = '0;
   logic frame_done;
   logic overflow;
   logic [$clog2(DEPTH):0] level;

   conv_out_if #(.WORD_W(WORD_W)) bus ();

   conv_out_packer #(
      .PIX_W(PIX_W), .WORD_W(WORD_W), .FIFO_DEPTH(DEPTH), .FRAME_PIX(FRAME_PIX)
   ) dut (
      .clk(clk), .rst(rst), .clear(clear), .valid_in(valid_in), .px_in(px_in),
      .m(bus), .frame_done(frame_done), .overflow(overflow), .level(level)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Reference model: pixel list for the word being built, queue of {last, word}.
   logic [32:0] exp_q[$];
   logic [7:0]  cur[$];
   bit          cur_last;
   int          pos;
   bit          exp_ovf;
   bit          exp_fd;

   function automatic void model_clear();
      exp_q.delete();
      cur.delete();
      cur_last = 1'b0;
      pos = 0;
      exp_ovf = 1'b0;
      exp_fd = 1'b0;
   endfunction

   function automatic bit exp_valid();
      return exp_q.size() != 0;
   endfunction

   function automatic logic [31:0] exp_data();
      if (exp_q.size() == 0) return 32'h0;
      return exp_q[0][31:0];
   endfunction

   function automatic bit exp_last();
      if (exp_q.size() == 0) return 1'b0;
      return exp_q[0][32];
   endfunction

   function automatic bit next_completes();
      return (cur.size() == P - 1) || (FLUSH && pos == FRAME_PIX - 1);
   endfunction

   task automatic step(input bit v, input logic [7:0] px, input bit rdy, input bit clr, input bit rs);
      bit pop;
      bit done;
      logic [31:0] w;
      valid_in = v;
      px_in = px;
      bus.m_ready = rdy;
      clear = clr;
      rst = rs;
      pop = exp_valid() && rdy;
      if (clr || rs) begin
         model_clear();
      end else begin
         exp_fd = 1'b0;
         if (pop) begin
            exp_fd = exp_q[0][32];
            void'(exp_q.pop_front());
         end
         if (v) begin
            cur.push_back(px);
            if (pos == FRAME_PIX - 1) cur_last = 1'b1;
            done = (cur.size() == P) || (FLUSH && pos == FRAME_PIX - 1);
            pos = (pos + 1) % FRAME_PIX;
            if (done) begin
               w = 32'h0;
               foreach (cur[i]) w = w | (32'(cur[i]) << (8 * i));
               if (exp_q.size() < DEPTH) exp_q.push_back({cur_last, w});
               else exp_ovf = 1'b1;
               cur.delete();
               cur_last = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      clear = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.m_valid); end
      total++; if (bus.m_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", bus.m_data); end
      total++; if (bus.m_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", bus.m_last); end
      total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b want=0", frame_done); end
   endtask

   task automatic test_basic();
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
         if (i == 4) begin
            total++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h04030201 || bus.m_last !== 1'b0) begin
               bad++; $display("FAIL basic_w0 got=%b/%h/%b want=1/04030201/0", bus.m_valid, bus.m_data, bus.m_last);
            end
         end
         total++; if (bus.m_data !== exp_data() || bus.m_last !== exp_last()) begin
            bad++; $display("FAIL basic_head got=%h/%b want=%h/%b", bus.m_data, bus.m_last, exp_data(), exp_last());
         end
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      total++; if (level !== 3'd0) begin bad++; $display("FAIL basic_level got=%0d want=0", level); end
   endtask

   task automatic test_flush();
      step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
         if (i == 3) begin
            total++; if (bus.m_data !== 32'h13121110 || bus.m_last !== 1'b0) begin
               bad++; $display("FAIL flush_w0 got=%h/%b want=13121110/0", bus.m_data, bus.m_last);
            end
         end
      end
`ifdef CONV_OUT_FLUSH_EN
      total++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h00001514 || bus.m_last !== 1'b1) begin
         bad++; $display("FAIL flush_w1 got=%b/%h/%b want=1/00001514/1", bus.m_valid, bus.m_data, bus.m_last);
      end
`else
      total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL noflush_empty got=%b want=0", bus.m_valid); end
      step(1'b1, 8'hA0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'hA1, 1'b1, 1'b0, 1'b0);
      total++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'hA1A01514 || bus.m_last !== 1'b1) begin
         bad++; $display("FAIL noflush_w1 got=%b/%h/%b want=1/a1a01514/1", bus.m_valid, bus.m_data, bus.m_last);
      end
`endif
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL fd_early got=%b want=0", frame_done); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL fd_pulse got=%b want=1", frame_done); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL fd_width got=%b want=0", frame_done); end
   endtask

   task automatic test_overflow();
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
         total++; if (overflow !== exp_ovf || level !== 3'(exp_q.size())) begin
            bad++; $display("FAIL ovf_fill px=%0d got=%b/%0d want=%b/%0d", i, overflow, level, exp_ovf, exp_q.size());
         end
      end
      total++; if (level !== 3'd4 || overflow !== 1'b1) begin
         bad++; $display("FAIL ovf_end got=%0d/%b want=4/1", level, overflow);
      end
      total++; if (bus.m_data !== 32'h04030201) begin bad++; $display("FAIL ovf_head got=%h want=04030201", bus.m_data); end
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         total++; if (bus.m_valid !== exp_valid() || bus.m_data !== exp_data() || bus.m_last !== exp_last()) begin
            bad++; $display("FAIL ovf_drain got=%b/%h/%b want=%b/%h/%b", bus.m_valid, bus.m_data, bus.m_last, exp_valid(), exp_data(), exp_last());
         end
      end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
   endtask

   task automatic test_full_pop();
      int px;
      px = 8'h40;
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      for (int n = 0; n < 64 && exp_q.size() < DEPTH; n++) begin
         step(1'b1, 8'(px), 1'b0, 1'b0, 1'b0);
         px++;
      end
      for (int n = 0; n < 8 && !next_completes(); n++) begin
         step(1'b1, 8'(px), 1'b0, 1'b0, 1'b0);
         px++;
      end
      total++; if (level !== 3'd4) begin bad++; $display("FAIL full_pre got=%0d want=4", level); end
      step(1'b1, 8'(px), 1'b1, 1'b0, 1'b0);
      total++; if (overflow !== 1'b0 || level !== 3'd4) begin
         bad++; $display("FAIL full_pop got=%b/%0d want=0/4", overflow, level);
      end
      for (int i = 0; i < 5; i++) begin
         total++; if (bus.m_valid !== exp_valid() || bus.m_data !== exp_data() || bus.m_last !== exp_last()) begin
            bad++; $display("FAIL full_drain got=%b/%h/%b want=%b/%h/%b", bus.m_valid, bus.m_data, bus.m_last, exp_valid(), exp_data(), exp_last());
         end
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
   endtask

   task automatic test_reset_midword();
      step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      step(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      step(1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
      total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_early got=%b want=0", bus.m_valid); end
      step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
      total++; if (bus.m_data !== 32'h77665544 || level !== 3'd1) begin
         bad++; $display("FAIL rstmid_word got=%h/%0d want=77665544/1", bus.m_data, level);
      end
   endtask

   task automatic test_random();
      bit v, r, c;
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      for (int n = 0; n < 800; n++) begin
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 9) < 6);
         c = ($urandom_range(0, 199) == 0);
         step(v, 8'($urandom), r, c, 1'b0);
         total++; if (bus.m_valid !== exp_valid() || bus.m_data !== exp_data() || bus.m_last !== exp_last()) begin
            bad++; $display("FAIL rnd_head cyc=%0d got=%b/%h/%b want=%b/%h/%b", n, bus.m_valid, bus.m_data, bus.m_last, exp_valid(), exp_data(), exp_last());
         end
         total++; if (level !== 3'(exp_q.size()) || overflow !== exp_ovf || frame_done !== exp_fd) begin
            bad++; $display("FAIL rnd_ctrl cyc=%0d got=%0d/%b/%b want=%0d/%b/%b", n, level, overflow, frame_done, exp_q.size(), exp_ovf, exp_fd);
         end
      end
   endtask

   initial begin
      bus.m_ready = 1'b0;
      model_clear();
      test_reset();
      test_basic();
      test_flush();
      test_overflow();
      test_full_pop();
      test_reset_midword();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/conv_out_packer.md
# conv_out_packer

Downstream stage of the 3x3 convolution core. It consumes the core's one-pixel-per-clock output stream, packs `WORD_W/PIX_W` pixels into bus-width words, and buffers them in a first-word-fall-through FIFO. The FIFO drains over a valid/ready master interface toward the LiteX DMA/CSR side. It also tracks frame boundaries and reports overflow, because the convolution core has no backpressure.

## Interface
Parameters:
- `PIX_W`, 8: pixel width in bits.
- `WORD_W`, 32: output word width. Must be an integer multiple of `PIX_W`. `P = WORD_W/PIX_W` lanes.
- `FIFO_DEPTH`, 16: FIFO depth in words. Must be a power of 2, ≥2.
- `FRAME_PIX`, 15876: output pixels per frame, (128-2)*(128-2).

Ports:
- `clk`, in, 1: clock. Single clock domain. Everything is sampled on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `clear`, in, 1: synchronous soft clear. Same effect as `rst`; `rst` has priority.
- `valid_in`, in, 1: pixel strobe, driven from the convolution core's `valid_out`.
- `px_in`, in, `PIX_W`: pixel value, driven from the core's `px_out`.
- `m_valid`, out, 1: FIFO non-empty.
- `m_ready`, in, 1: consumer accepts a word.
- `m_data`, out, `WORD_W`: head-of-FIFO word.
- `m_last`, out, 1: head word contains the frame's final pixel.
- `frame_done`, out, 1: one-cycle pulse at the end of a frame.
- `overflow`, out, 1: sticky flag, set when a completed word is dropped.
- `level`, out, `$clog2(FIFO_DEPTH)+1`: number of words currently in the FIFO.

## Operation
- **Lane placement:**
  - A pixel is accepted on every cycle with `valid_in=1`.
  - Pixel at lane k occupies `word[PIX_W*k +: PIX_W]`, little-endian. The first pixel goes to lane 0.
  - The lane index counts 0..P-1 and wraps.
- **Frame counter:**
  - `pix_cnt` (internal) counts 0..`FRAME_PIX-1`.
  - It wraps to 0 after the pixel where `pix_cnt==FRAME_PIX-1`; that pixel is the frame's last pixel.
- **Word completion:**
  - A word completes when the accepted pixel lands in lane P-1, or is the frame's last pixel (see Configuration).
  - The completed word is pushed together with a last bit equal to "contains the frame's last pixel".
- **Push:**
  - The word is written if the FIFO is not full, or if it is full but a pop happens in the same cycle.
  - Otherwise the word is dropped and `overflow` is set to 1. `overflow` holds until `rst` or `clear`.
  - Packing continues regardless of whether the word was dropped.
- **Pop:** occurs when `m_valid && m_ready`. Words leave in push order.
- **Empty FIFO:** `m_data` and `m_last` read 0 while `m_valid=0`.
- **`frame_done`:** asserts for exactly one cycle, in the cycle after a pop whose `m_last=1`.
- **`level`:**
  - +1 on push only, −1 on pop only, unchanged when push and pop occur together.
  - Never exceeds `FIFO_DEPTH`.
- **Soft clear:** `clear` or `rst` with `valid_in` high in the same cycle discards that pixel.

## Timing
- **Reset values:** `m_valid=0`, `m_data=0`, `m_last=0`, `frame_done=0`, `overflow=0`, `level=0`. Lane index and `pix_cnt` are 0. FIFO pointers are 0.
- **Latency:** a pixel that completes a word at edge t makes `m_valid=1` with that word on `m_data` after edge t, i.e. 1 cycle.
- **Handshake:** `m_data`/`m_last` are stable while `m_valid && !m_ready`. `m_valid` never drops without a pop.
- **Throughput:** one pixel in per cycle; one word out per cycle.
- **Reset or clear mid-word:** the partial word is discarded. The next accepted pixel goes to lane 0 with `pix_cnt=0`.

## Configuration
Macro `CONV_OUT_FLUSH_EN`.
- **Defined:** when the frame's last pixel lands in lane k<P-1, the partial word is pushed immediately with `m_last=1`. Lanes k+1..P-1 are zero. The next pixel starts lane 0.
- **Undefined:**
  - Words complete only at lane P-1.
  - If `FRAME_PIX` is not a multiple of P, the last word of a frame is filled with the next frame's first pixels. It is still flagged `m_last=1`.
  - When `FRAME_PIX % P == 0`, output is identical to the defined case.

## Test plan
- **Basic packing:** `m_ready=1`, pixels 0x01..0x08 on consecutive cycles. Expect words 0x04030201 then 0x08070605, each visible 1 cycle after its 4th pixel, `m_last=0`, `level` back to 0.
- **Partial-word flush:** `FRAME_PIX=6`, `CONV_OUT_FLUSH_EN` defined, pixels 0x10..0x15. Expect 0x13121110 with `m_last=0`, then 0x00001514 with `m_last=1`, and `frame_done` high for 1 cycle after the second pop.
- **No flush:** same stimulus with the macro undefined, followed by pixels 0xA0,0xA1. Expect the second word to be 0xA1A01514 with `m_last=1`.
- **Overflow:** `FIFO_DEPTH=4`, `m_ready=0`, 20 pixels. Expect `level=4`, `overflow=1` from the 5th word completion onward. A later drain yields the first 4 words in order, and `overflow` stays 1 until `clear`.
- **Full with simultaneous pop:** FIFO full, `m_ready=1` on the cycle a word completes. Expect no overflow, `level` stays 4, and the new word appears after the remaining 3.
- **Reset mid-word:** pixels 0x11,0x22,0x33, then `rst` for 1 cycle, then 0x44..0x77. Expect the single word 0x77665544 with no residue from before reset.
